// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the single-port SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_ACCESS_ENC = 2'd1;
    localparam logic [1:0] ST_READ_ENC   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE_ENC,
        ACCESS = ST_ACCESS_ENC,
        READ   = ST_READ_ENC
    } state_e;

    // Round-robin successor: the requester after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after ptr (wrapping) gets a one-hot grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   grant_idx_c
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && valid[idx]) begin
                found          = 1'b1;
                grant_c[idx]   = 1'b1;
                grant_idx_c    = idx;
            end
        end
    end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Round-robin sequencer sharing one 1RW SRAM macro among NUM_REQ requesters.
// Define SRAM_ARB_PERF_CNT_EN to add per-requester saturating grant counters (grant_cnt).
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0]           sram_addr,
    output logic                            sram_csb,
    output logic                            sram_web,
    output logic                            sram_oeb,
    inout  wire  [DATA_WIDTH-1:0]           sram_data
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]        grant_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_e                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        win_idx;
    logic [PTR_W-1:0]        cur_id;
    logic                    cur_we;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    drive_q;
    logic [NUM_REQ-1:0]      grant;
    logic                    handshake;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .valid       (req_valid),
        .ptr         (rr_ptr),
        .grant_c     (grant),
        .grant_idx_c (win_idx)
    );

    // Grants are offered only while idle; reset forces ready low immediately.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign handshake = |req_ready;

    // Data bus is driven only during a write access cycle; oeb is never low then.
    assign sram_data = drive_q ? wdata_q : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            cur_we    <= 1'b0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            sram_addr <= '0;
            sram_csb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_oeb  <= 1'b1;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cur_id    <= win_idx;
                        cur_we    <= req_we[win_idx];
                        sram_addr <= addr_arr[win_idx];
                        wdata_q   <= wdata_arr[win_idx];
                        rr_ptr    <= PTR_W'(rr_next(32'(win_idx), NUM_REQ));
                        sram_csb  <= 1'b0;
                        sram_web  <= ~req_we[win_idx];
                        sram_oeb  <= 1'b1;
                        drive_q   <= req_we[win_idx];
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    drive_q <= 1'b0;
                    if (cur_we) begin
                        sram_csb          <= 1'b1;
                        sram_web          <= 1'b1;
                        rsp_valid[cur_id] <= 1'b1;
                        state             <= IDLE;
                    end else begin
                        sram_web <= 1'b1;
                        sram_oeb <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    rsp_rdata         <= sram_data;
                    sram_csb          <= 1'b1;
                    sram_oeb          <= 1'b1;
                    rsp_valid[cur_id] <= 1'b1;
                    state             <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_PERF_CNT_EN
    // One saturating grant counter per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (req_ready[g] && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter with a behavioural SRAM macro stand-in and a transaction-level model.
module tb_sram_1rw_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   sram_addr;
    logic            sram_csb, sram_web, sram_oeb;
    wire  [DW-1:0]   sram_data;
`ifdef SRAM_ARB_PERF_CNT_EN
    logic [N*16-1:0] grant_cnt;
`endif

    sram_1rw_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_addr (sram_addr),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb),
        .sram_data (sram_data)
`ifdef SRAM_ARB_PERF_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // Idealised 1RW macro: writes and read address sampled on clk, output enabled by oeb.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [AW-1:0] sram_raddr;
    always @(posedge clk) begin
        if (!sram_csb && !sram_web) sram_mem[sram_addr] <= sram_data;
        if (!sram_csb && sram_web)  sram_raddr <= sram_addr;
    end
    assign sram_data = !sram_oeb ? sram_mem[sram_raddr] : 'z;

    // Reference model state
    typedef struct { int due; int id; logic we; logic known; logic [DW-1:0] data; } pend_t;
    pend_t         pq[$];
    logic [DW-1:0] ref_mem   [0:(1<<AW)-1];
    logic          ref_known [0:(1<<AW)-1];
    int            ncyc, free_at, last_grant, act_hs;
    logic          act_we;
    logic [AW-1:0] act_addr;
    int            hs_id;
    int            grants[$];
    int            obs_hs_cyc, obs_rsp_cyc;
    logic [N-1:0]  obs_rsp_vec;
    logic [DW-1:0] obs_rdata;
    int            checks = 0;
    int            fails  = 0;

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; int gap; } cmd_t;
    cmd_t cmds [N][64];
    int   cmd_n [N];
    int   cmd_i [N];
    int   gap_left [N];

    typedef struct { int id; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp_rdata; int exp_lat; } vec_t;
    vec_t vecs [6];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle model comparison, sampled on the falling edge.
    task automatic model_check();
        logic [N-1:0]  exp_ready, exp_rsp, hs;
        logic          busy, found, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            hid;
        hs_id = -1;
        if (rst) begin
            pq.delete();
            free_at    = 0;
            last_grant = N - 1;
            ncyc       = 0;
            chk("rst_ready", 64'(req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_rdata", 64'(rsp_rdata), 64'(0));
            chk("rst_addr", 64'(sram_addr), 64'(0));
            chk("rst_ctrl", 64'({sram_csb, sram_web, sram_oeb}), 64'(3'b111));
            return;
        end
        ncyc++;
        busy      = ncyc < free_at;
        exp_ready = '0;
        found     = 1'b0;
        if (!busy) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last_grant + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    exp_ready[idx] = 1'b1;
                end
            end
        end
        chk("ready", 64'(req_ready), 64'(exp_ready));
        chk("csb", 64'(sram_csb), 64'(!busy));
        chk("web", 64'(sram_web), 64'(!(busy && act_we && ncyc == act_hs + 1)));
        chk("oeb", 64'(sram_oeb), 64'(!(busy && !act_we && ncyc == act_hs + 2)));
        chk("contention", 64'(!sram_oeb && !sram_web), 64'(0));
        if (busy) chk("sram_addr", 64'(sram_addr), 64'(act_addr));
        exp_rsp = '0;
        if (pq.size() > 0 && pq[0].due == ncyc) begin
            exp_rsp[pq[0].id] = 1'b1;
            if (!pq[0].we && pq[0].known) chk("rdata", 64'(rsp_rdata), 64'(pq[0].data));
            void'(pq.pop_front());
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (rsp_valid != '0) begin
            obs_rsp_cyc = ncyc;
            obs_rsp_vec = rsp_valid;
            obs_rdata   = rsp_rdata;
        end
        hs = req_valid & req_ready;
        if (hs != '0) begin
            hid = 0;
            for (int i = 0; i < N; i++) if (hs[i]) hid = i;
            we = req_we[hid];
            a  = req_addr[hid*AW +: AW];
            d  = req_wdata[hid*DW +: DW];
            pq.push_back('{due: ncyc + (we ? 2 : 3), id: hid, we: we, known: ref_known[a], data: ref_mem[a]});
            if (we) begin
                ref_mem[a]   = d;
                ref_known[a] = 1'b1;
            end
            free_at    = ncyc + (we ? 2 : 3);
            act_hs     = ncyc;
            act_we     = we;
            act_addr   = a;
            last_grant = hid;
            grants.push_back(hid);
            obs_hs_cyc = ncyc;
            hs_id      = hid;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic load_one(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
        cmds[id][cmd_n[id]] = '{we: we, addr: a, data: d, gap: gap};
        cmd_n[id]++;
    endtask

    task automatic clear_cmds();
        for (int i = 0; i < N; i++) cmd_n[i] = 0;
    endtask

    // Present queued commands, holding each stable until accepted, then drain responses.
    task automatic run_cmds(input int budget);
        int   cyc;
        logic done;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            cmd_i[i]    = 0;
            gap_left[i] = (cmd_n[i] > 0) ? cmds[i][0].gap : 0;
        end
        done = 1'b0;
        while (!done && cyc < budget) begin
            for (int i = 0; i < N; i++) begin
                if (cmd_i[i] < cmd_n[i] && gap_left[i] == 0) begin
                    req_valid[i]             = 1'b1;
                    req_we[i]                = cmds[i][cmd_i[i]].we;
                    req_addr[i*AW +: AW]     = cmds[i][cmd_i[i]].addr;
                    req_wdata[i*DW +: DW]    = cmds[i][cmd_i[i]].data;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            tick();
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (hs_id == i) begin
                    cmd_i[i]++;
                    if (cmd_i[i] < cmd_n[i]) gap_left[i] = cmds[i][cmd_i[i]].gap;
                end else if (gap_left[i] > 0) begin
                    gap_left[i]--;
                end
            end
            done = (pq.size() == 0);
            for (int i = 0; i < N; i++) if (cmd_i[i] < cmd_n[i]) done = 1'b0;
        end
        req_valid = '0;
        chk("run_done", 64'(done), 64'(1));
    endtask

    task automatic do_vec(input vec_t v);
        logic [N-1:0] onehot;
        clear_cmds();
        load_one(v.id, v.we, v.addr, v.wdata, 0);
        obs_hs_cyc  = -100;
        obs_rsp_cyc = 0;
        obs_rsp_vec = '0;
        run_cmds(50);
        onehot = '0;
        onehot[v.id] = 1'b1;
        chk("vec_latency", 64'(obs_rsp_cyc - obs_hs_cyc), 64'(v.exp_lat));
        chk("vec_rsp_id", 64'(obs_rsp_vec), 64'(onehot));
        if (!v.we) chk("vec_rdata", 64'(obs_rdata), 64'(v.exp_rdata));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gstart;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        vecs[0] = '{id: 0, we: 1'b1, addr: 11'h005, wdata: 32'hDEADBEEF, exp_rdata: 32'h0,        exp_lat: 2};
        vecs[1] = '{id: 1, we: 1'b0, addr: 11'h005, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF, exp_lat: 3};
        vecs[2] = '{id: 0, we: 1'b1, addr: 11'h7FF, wdata: 32'h0,        exp_rdata: 32'h0,        exp_lat: 2};
        vecs[3] = '{id: 1, we: 1'b0, addr: 11'h7FF, wdata: 32'h0,        exp_rdata: 32'h0,        exp_lat: 3};
        vecs[4] = '{id: 0, we: 1'b1, addr: 11'h000, wdata: 32'hFFFFFFFF, exp_rdata: 32'h0,        exp_lat: 2};
        vecs[5] = '{id: 1, we: 1'b0, addr: 11'h000, wdata: 32'h0,        exp_rdata: 32'hFFFFFFFF, exp_lat: 3};

        // Reset with both requesters asserting valid
        rst       = 1'b1;
        req_valid = '1;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        clear_cmds();
        tick();
        tick();
        req_valid = '0;
        rst       = 1'b0;
        tick();

        // Write then read at 0x005
        do_vec(vecs[0]);
        do_vec(vecs[1]);

        // Both requesters continuously valid: grants must alternate 0,1,0,1...
        clear_cmds();
        for (int k = 0; k < 4; k++) begin
            load_one(0, 1'b0, AW'(k), '0, 0);
            load_one(1, 1'b0, AW'(k + 4), '0, 0);
        end
        gstart = grants.size();
        run_cmds(100);
        chk("rr_count", 64'(grants.size() - gstart), 64'(8));
        for (int k = 0; k < 8; k++) begin
            if (gstart + k < grants.size()) chk("rr_order", 64'(grants[gstart + k]), 64'(k % 2));
        end

        // Address range ends
        for (int k = 2; k < 6; k++) do_vec(vecs[k]);

        // Reset while requester 1 is in its read data phase
        hs_id = -1;
        req_valid = 2'b10;
        req_we    = '0;
        req_addr[AW +: AW] = 11'h005;
        for (int k = 0; k < 20 && hs_id != 1; k++) tick();
        chk("t5_grant", 64'(hs_id), 64'(1));
        req_valid = '0;
        tick();
        chk("t5_in_read", 64'(sram_oeb), 64'(0));
        rst = 1'b1;
        #1;
        chk("t5_async_ctrl", 64'({sram_csb, sram_web, sram_oeb}), 64'(3'b111));
        chk("t5_async_rsp", 64'(rsp_valid), 64'(0));
        chk("t5_async_ready", 64'(req_ready), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        do_vec('{id: 0, we: 1'b0, addr: 11'h005, wdata: 32'h0, exp_rdata: 32'hDEADBEEF, exp_lat: 3});
        do_vec('{id: 1, we: 1'b1, addr: 11'h123, wdata: 32'hA5A5_0F0F, exp_rdata: 32'h0, exp_lat: 2});
        do_vec('{id: 1, we: 1'b0, addr: 11'h123, wdata: 32'h0, exp_rdata: 32'hA5A5_0F0F, exp_lat: 3});

        // Randomised traffic against the model
        clear_cmds();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 30; k++) begin
                load_one(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2));
            end
        end
        run_cmds(2000);

`ifdef SRAM_ARB_PERF_CNT_EN
        // Grant counters after 5 grants to req0 and 3 to req1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        clear_cmds();
        for (int k = 0; k < 5; k++) load_one(0, 1'b1, AW'(k + 32), $urandom, 0);
        for (int k = 0; k < 3; k++) load_one(1, 1'b0, AW'(k + 32), '0, 0);
        run_cmds(200);
        chk("grant_cnt", 64'(grant_cnt), 64'({16'd3, 16'd5}));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
